ternary_sampler_stream: RTL and testbench

//  Parametrised streaming ternary sampler for NTRU-HRSS key generation.
//  - Reduces each input byte mod 3 into one 2-bit ternary coefficient.
//  - LANES bytes per beat, valid/ready on both sides, ragged final beat.
//  - Sits between the random-byte source and the polynomial coefficient store.
//  - Selectable coefficient encoding: unsigned or signed.

---
 rtl/ternary_sampler_stream.sv | 175 +++++++++++++++++
 tb/tb_ternary_sampler_stream.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_sampler_stream.sv
// Streaming ternary sampler: reduces each input byte mod 3 to a 2-bit coefficient,
// LANES bytes per beat, with a single registered output stage and a ragged final beat.
module ternary_sampler_stream #(
    parameter int unsigned N_COEF = 701,
    parameter int unsigned LANES  = 4,
    parameter int unsigned CNT_W  = $clog2(N_COEF + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_en,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*LANES-1:0]   coef_data,
    output logic [LANES-1:0]     coef_keep,
    output logic                 coef_valid,
    input  logic                 coef_ready,
    output logic                 coef_last,
    output logic                 busy,
    output logic                 done
);

    // Wide enough that count + LANES never wraps, for any LANES up to 16.
    localparam int unsigned SUM_W = CNT_W + 5;
    localparam logic [SUM_W-1:0] NCOEF_S = SUM_W'(N_COEF);
    localparam logic [SUM_W-1:0] LANES_S = SUM_W'(LANES);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]   count_q, count_d;
    logic               signed_q, signed_d;
    logic [2*LANES-1:0] coef_data_q, coef_data_d;
    logic [LANES-1:0]   coef_keep_q, coef_keep_d;
    logic               coef_last_q, coef_last_d;
    logic               coef_valid_q, coef_valid_d;

    logic [SUM_W-1:0]   count_ext;
    logic [SUM_W-1:0]   count_sum;
    logic [SUM_W-1:0]   remain;
    logic               beat_last;
    logic               in_fire;
    logic               out_fire;
    logic               ready_int;
    logic [2*LANES-1:0] lane_code;
    logic [LANES-1:0]   lane_keep;

    // Byte mod 3 by folding base-4 digits (4 == 1 mod 3), exact for 0..255.
    function automatic logic [1:0] mod3(input logic [7:0] b);
        logic [3:0] s1;
        logic [2:0] s2;
        logic [1:0] s3;
        s1 = 4'(b[7:6]) + 4'(b[5:4]) + 4'(b[3:2]) + 4'(b[1:0]);
        s2 = 3'(s1[3:2]) + 3'(s1[1:0]);
        s3 = s2[1:0] + 2'(s2[2]);
        return (s3 == 2'd3) ? 2'd0 : s3;
    endfunction

    // Residue 2 becomes -1 (2'b11) in signed mode.
    function automatic logic [1:0] encode(input logic [7:0] b, input logic sgn);
        logic [1:0] r;
        r = mod3(b);
        return (sgn && (r == 2'd2)) ? 2'b11 : r;
    endfunction

    // Handshake qualifiers and tail detection for the current beat.
    always_comb begin
        ready_int = (state_q == StRun) && (!coef_valid_q || coef_ready);
        in_fire   = in_valid && ready_int;
        out_fire  = coef_valid_q && coef_ready;
        count_ext = SUM_W'(count_q);
        count_sum = count_ext + LANES_S;
        beat_last = (count_sum >= NCOEF_S);
        remain    = NCOEF_S - count_ext;
    end

    // Per-lane reduction and keep mask; masked tail lanes are forced to zero.
    always_comb begin
        lane_code = '0;
        lane_keep = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_keep[k] = !beat_last || (SUM_W'(k) < remain);
            if (lane_keep[k]) begin
                lane_code[2*k +: 2] = encode(in_data[8*k +: 8], signed_q);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (in_fire && beat_last) state_d = StDrain;
            StDrain: if (out_fire) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values for the job counter, latched encoding and output register.
    always_comb begin
        count_d      = count_q;
        signed_d     = signed_q;
        coef_data_d  = coef_data_q;
        coef_keep_d  = coef_keep_q;
        coef_last_d  = coef_last_q;
        coef_valid_d = coef_valid_q;

        if ((state_q == StIdle) && start) begin
            count_d  = '0;
            signed_d = signed_en;
        end else if (in_fire) begin
            // Saturate at N_COEF on the final beat so the counter cannot wrap.
            count_d = beat_last ? CNT_W'(N_COEF) : count_q + CNT_W'(LANES);
        end

        // A load wins over a drain so back-to-back beats flow without a bubble.
        if (in_fire) begin
            coef_data_d  = lane_code;
            coef_keep_d  = lane_keep;
            coef_last_d  = beat_last;
            coef_valid_d = 1'b1;
        end else if (out_fire) begin
            coef_valid_d = 1'b0;
        end
    end

    // Datapath and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            signed_q     <= 1'b0;
            coef_data_q  <= '0;
            coef_keep_q  <= '0;
            coef_last_q  <= 1'b0;
            coef_valid_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            signed_q     <= signed_d;
            coef_data_q  <= coef_data_d;
            coef_keep_q  <= coef_keep_d;
            coef_last_q  <= coef_last_d;
            coef_valid_q <= coef_valid_d;
        end
    end

    // Output decode.
    always_comb begin
        in_ready   = ready_int;
        coef_data  = coef_data_q;
        coef_keep  = coef_keep_q;
        coef_last  = coef_last_q;
        coef_valid = coef_valid_q;
        busy       = (state_q == StRun) || (state_q == StDrain);
        done       = (state_q == StDone);
    end

endmodule

// File: tb/tb_ternary_sampler_stream.sv
// Randomized self-checking bench for ternary_sampler_stream against a byte-stream model.
module tb_ternary_sampler_stream;

    localparam int unsigned N_COEF = 701;
    localparam int unsigned LANES  = 4;
    localparam int unsigned BEATS  = (N_COEF + LANES - 1) / LANES;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 signed_en = 1'b0;
    logic [8*LANES-1:0]   in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [2*LANES-1:0]   coef_data;
    logic [LANES-1:0]     coef_keep;
    logic                 coef_valid;
    logic                 coef_ready = 1'b0;
    logic                 coef_last;
    logic                 busy;
    logic                 done;

    int checks = 0;
    int failures = 0;

    logic [7:0] job_bytes [BEATS*LANES];

    always #5 clk = ~clk;

    ternary_sampler_stream #(
        .N_COEF(N_COEF),
        .LANES (LANES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_en (signed_en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coef_data (coef_data),
        .coef_keep (coef_keep),
        .coef_valid(coef_valid),
        .coef_ready(coef_ready),
        .coef_last (coef_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference coefficient: plain integer remainder, -1 coded as 2'b11.
    function automatic logic [1:0] ref_code(input logic [7:0] b, input bit sgn);
        int r;
        r = int'(b) % 3;
        if (sgn && r == 2) return 2'b11;
        return 2'(r);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_in_ready"}, in_ready, 0);
        check_eq({tag, "_coef_valid"}, coef_valid, 0);
        check_eq({tag, "_coef_last"}, coef_last, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_coef_data"}, coef_data, 0);
        check_eq({tag, "_coef_keep"}, coef_keep, 0);
    endtask

    // Pattern selects how lane 0 is driven so that all 256 byte values get covered.
    task automatic fill_bytes(input int pattern);
        logic [7:0] v;
        for (int i = 0; i < int'(BEATS*LANES); i++) job_bytes[i] = 8'($urandom());
        for (int j = 0; j < int'(BEATS); j++) begin
            case (pattern)
                0: v = 8'(j);
                1: v = 8'(j + 80);
                2: v = 8'(j - 1);
                default: v = job_bytes[j*LANES];
            endcase
            job_bytes[j*LANES] = v;
        end
        if (pattern == 0) begin
            job_bytes[0] = 8'hFF; job_bytes[1] = 8'h07; job_bytes[2] = 8'h05; job_bytes[3] = 8'h00;
        end else if (pattern == 2) begin
            job_bytes[0] = 8'h02; job_bytes[1] = 8'h04; job_bytes[2] = 8'h03; job_bytes[3] = 8'h80;
        end
    endtask

    task automatic run_job(input int pattern, input bit sgn, input int ready_pct,
                           input int valid_pct, input int abort_at, input bit start_noise);
        int in_idx;
        int out_idx;
        int cyc;
        int exp_done_cyc;
        bit finished;
        bit stalled;
        bit loaded;
        logic [2*LANES-1:0] sv_data;
        logic [LANES-1:0]   sv_keep;
        logic               sv_last;
        logic [2*LANES-1:0] exp_data;
        logic [LANES-1:0]   exp_keep;
        int idx;

        in_idx = 0; out_idx = 0; cyc = 0; exp_done_cyc = -1;
        finished = 0; stalled = 0; loaded = 0;
        sv_data = '0; sv_keep = '0; sv_last = 1'b0;
        fill_bytes(pattern);

        @(posedge clk); #1;
        start = 1'b1;
        signed_en = sgn;
        @(posedge clk); #1;
        start = 1'b0;

        while (!finished && cyc < 6000) begin
            in_valid = ($urandom_range(99) < valid_pct);
            if (in_idx < int'(BEATS)) begin
                for (int k = 0; k < int'(LANES); k++) in_data[8*k +: 8] = job_bytes[in_idx*LANES + k];
            end else begin
                in_valid = 1'b1;
                in_data = 32'($urandom());
            end
            coef_ready = ($urandom_range(99) < ready_pct);
            signed_en  = 1'($urandom_range(1));
            start      = start_noise && ($urandom_range(19) == 0);
            #4;

            if (loaded) check_eq("latency_valid", coef_valid, 1);
            if (stalled) begin
                check_eq("stall_valid", coef_valid, 1);
                check_eq("stall_data", coef_data, sv_data);
                check_eq("stall_keep", coef_keep, sv_keep);
                check_eq("stall_last", coef_last, sv_last);
            end
            check_eq("done", done, (cyc == exp_done_cyc) ? 1 : 0);
            check_eq("busy", busy, (cyc == exp_done_cyc) ? 0 : 1);
            if (coef_valid && !coef_ready) check_eq("ready_blocked", in_ready, 0);
            if (in_idx >= int'(BEATS)) check_eq("no_extra_accept", in_ready, 0);
            else if (ready_pct == 100) check_eq("full_rate", in_ready, 1);

            loaded = in_valid && in_ready;
            if (loaded) in_idx++;
            stalled = coef_valid && !coef_ready;
            sv_data = coef_data; sv_keep = coef_keep; sv_last = coef_last;

            if (coef_valid && coef_ready) begin
                if (out_idx >= int'(BEATS)) begin
                    check_eq("extra_out_beat", out_idx, BEATS - 1);
                end else begin
                    for (int k = 0; k < int'(LANES); k++) begin
                        idx = out_idx*LANES + k;
                        exp_keep[k] = (idx < int'(N_COEF));
                        exp_data[2*k +: 2] = exp_keep[k] ? ref_code(job_bytes[idx], sgn) : 2'b00;
                    end
                    check_eq("coef_data", coef_data, exp_data);
                    check_eq("coef_keep", coef_keep, exp_keep);
                    check_eq("coef_last", coef_last, (out_idx == int'(BEATS) - 1) ? 1 : 0);
                    if (out_idx == int'(BEATS) - 1) begin
                        check_eq("tail_keep", coef_keep, 4'b0001);
                        exp_done_cyc = cyc + 1;
                    end
                end
                out_idx++;
            end

            if (cyc == exp_done_cyc) begin
                finished = 1;
                start = 1'b1;  // lands on the DONE cycle and must be ignored
            end

            if (abort_at >= 0 && in_idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_idle_outputs("abort");
                #2;
                rst_n = 1'b1;
                in_valid = 1'b0;
                start = 1'b0;
                for (int c = 0; c < 6; c++) begin
                    @(negedge clk);
                    check_eq("abort_no_done", done, 0);
                    check_eq("abort_idle", busy, 0);
                end
                return;
            end

            cyc++;
            @(posedge clk); #1;
        end

        check_eq("job_finished", finished, 1);
        check_eq("in_beats", in_idx, BEATS);
        check_eq("out_beats", out_idx, BEATS);
        start = 1'b0;
        in_valid = 1'b0;
        coef_ready = 1'b1;
        #4;
        check_eq("post_done_busy", busy, 0);
        check_eq("post_done_pulse", done, 0);
        check_eq("post_done_valid", coef_valid, 0);
        check_eq("post_done_ready", in_ready, 0);
    endtask

    initial begin
        #3;
        check_idle_outputs("reset");
        #9;
        rst_n = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check_eq("idle_in_ready", in_ready, 0);
        in_valid = 1'b0;

        run_job(0, 1'b0, 100, 100, -1, 1'b0);
        run_job(1, 1'b0, 30, 80, -1, 1'b0);
        run_job(2, 1'b1, 30, 70, -1, 1'b1);
        run_job(3, 1'b0, 50, 90, 50, 1'b0);
        run_job(3, 1'b1, 60, 90, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
